// File: rtl/serial_subtract_ctrl_if.sv
// Handshake and result bundle for the bit-serial subtract unit.
// The requester drives start/operands; the unit drives status and result.
interface serial_subtract_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;
  logic             ovf;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start, op_a, op_b, borrow_in,
    input  busy, done, difference, borrow_out, ovf
  );

  // Subtract unit side.
  modport slave (
    input  start, op_a, op_b, borrow_in,
    output busy, done, difference, borrow_out, ovf
  );

endinterface : serial_subtract_ctrl_if

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor: computes op_a - op_b - borrow_in LSB first, one bit
// per clock, through a single one-bit full subtractor. The borrow rides in a
// flop between steps. Result, final borrow and signed overflow are registered
// and held from the done pulse until the next completed operation.

// One-bit full subtractor: d = a - b - bin, bout set when the step underflows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & (b | bin)) | (b & bin);

endmodule : full_subtractor

module serial_subtract_ctrl #(
  parameter int WIDTH = 8   // legal range 1..32; must match the interface WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtract_ctrl_if.slave bus
);

  // Bit counter sized so it can hold WIDTH-1 even when WIDTH is a power of two.
  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Control strobes decoded from the current state.
  logic load;   // capture new operands (accepted start)
  logic step;   // process one bit this cycle
  logic last;   // this step handles the MSB

  // Working registers.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             sign_a;
  logic             sign_b;

  // Registered outputs.
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;

  // Shared one-bit subtractor.
  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] res_nxt;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // The new bit enters at the MSB; after WIDTH steps bit 0 has reached the LSB.
  // Built as a wide shift so the expression stays legal for WIDTH == 1.
  logic [WIDTH:0] res_cat;
  assign res_cat = {fs_d, res_sh} >> 1;
  assign res_nxt = res_cat[WIDTH-1:0];

  assign last = (cnt == LAST_CNT);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its sources, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control decode; start is only honoured in IDLE or DONE.
  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and per-bit shifting of operands, result and borrow.
  // NOTE: the shift registers, counter and borrow flop are explicitly reset so
  // an aborted operation leaves no stale partial state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (load) begin
      a_sh   <= bus.op_a;
      b_sh   <= bus.op_b;
      brw    <= bus.borrow_in;
      cnt    <= '0;
      sign_a <= bus.op_a[WIDTH-1];
      sign_b <= bus.op_b[WIDTH-1];
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      brw    <= fs_bout;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result registers: updated only on the final (MSB) step, held otherwise.
  // Overflow: operand signs differ and the result sign disagrees with the minuend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (step && last) begin
      diff_q   <= res_nxt;
      borrow_q <= fs_bout;
      ovf_q    <= (sign_a ^ sign_b) & (fs_d ^ sign_a);
    end
  end

  // Status is a direct decode of the state register.
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.difference = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.ovf        = ovf_q;

endmodule : serial_subtract_ctrl

// File: tb/tb_serial_subtract_ctrl.sv
// Bench for serial_subtract_ctrl: an 8-bit and a 1-bit instance share clock
// and reset. Drivers push expected results into queues; monitors pop and
// compare on every done pulse and check that results hold between pulses.
module tb_serial_subtract_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtract_ctrl_if #(.WIDTH(8)) if8 ();
  serial_subtract_ctrl_if #(.WIDTH(1)) if1 ();

  serial_subtract_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_subtract_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct {
    logic [7:0] diff;
    logic       bo;
    logic       ovf;
  } exp8_t;

  typedef struct {
    logic diff;
    logic bo;
    logic ovf;
  } exp1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bo;
    logic       ovf;
  } vec_t;

  exp8_t q8[$];
  exp1_t q1[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp8_t      m;
    logic [8:0] r;
    r     = {1'b0, a} - {1'b0, b} - 9'(bin);
    m.diff = r[7:0];
    m.bo   = r[8];
    m.ovf  = (a[7] != b[7]) && (r[7] != a[7]);
    return m;
  endfunction

  // Monitor for the 8-bit unit: compare on done, check hold otherwise.
  logic [9:0] held8 = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held8 = '0;
    end else if (if8.done) begin
      check("done8_expected", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        exp8_t e;
        e = q8.pop_front();
        check("result8", {if8.borrow_out, if8.ovf, if8.difference}, {e.bo, e.ovf, e.diff});
      end
      held8 = {if8.borrow_out, if8.ovf, if8.difference};
    end else begin
      check("hold8", {if8.borrow_out, if8.ovf, if8.difference}, held8);
    end
  end

  // Monitor for the 1-bit unit.
  always @(negedge clk) begin
    if (rst_n && if1.done) begin
      check("done1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        exp1_t e;
        e = q1.pop_front();
        check("result1", {if1.borrow_out, if1.ovf, if1.difference}, {e.bo, e.ovf, e.diff});
      end
    end
  end

  // Issue one 8-bit operation and check busy/done timing around it.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input exp8_t e);
    @(negedge clk);
    if8.op_a      = a;
    if8.op_b      = b;
    if8.borrow_in = bin;
    if8.start     = 1'b1;
    q8.push_back(e);
    @(posedge clk);
    #1 if8.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("busy8", {if8.busy, if8.done}, 2'b10);
    end
    @(negedge clk);
    check("done8", {if8.busy, if8.done}, 2'b01);
  endtask

  task automatic issue1(input logic a, input logic b, input logic bin, input exp1_t e);
    @(negedge clk);
    if1.op_a      = a;
    if1.op_b      = b;
    if1.borrow_in = bin;
    if1.start     = 1'b1;
    q1.push_back(e);
    @(posedge clk);
    #1 if1.start = 1'b0;
    @(negedge clk);
    check("busy1", {if1.busy, if1.done}, 2'b10);
    @(negedge clk);
    check("done1", {if1.busy, if1.done}, 2'b01);
  endtask

  vec_t vecs[6] = '{
    '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0},
    '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0},
    '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
    '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1},
    '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0}
  };

  initial begin
    exp8_t e8;
    exp1_t e1;

    rst_n         = 1'b0;
    if8.start     = 1'b0;
    if8.op_a      = '0;
    if8.op_b      = '0;
    if8.borrow_in = 1'b0;
    if1.start     = 1'b0;
    if1.op_a      = '0;
    if1.op_b      = '0;
    if1.borrow_in = 1'b0;

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset8", {if8.busy, if8.done, if8.borrow_out, if8.ovf, if8.difference}, '0);
    check("reset1", {if1.busy, if1.done, if1.borrow_out, if1.ovf, if1.difference}, '0);

    // Directed vectors with hand-computed results.
    foreach (vecs[i]) begin
      e8 = '{diff: vecs[i].diff, bo: vecs[i].bo, ovf: vecs[i].ovf};
      issue8(vecs[i].a, vecs[i].b, vecs[i].bin, e8);
    end

    // Start during RUN is ignored; start held into DONE is accepted there.
    @(negedge clk);
    if8.op_a      = 8'h40;
    if8.op_b      = 8'h15;
    if8.borrow_in = 1'b0;
    if8.start     = 1'b1;
    q8.push_back('{diff: 8'h2B, bo: 1'b0, ovf: 1'b0});
    @(posedge clk);
    #1 if8.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("b2b_busy_a", {if8.busy, if8.done}, 2'b10);
      if (k == 3) begin
        if8.op_a  = 8'hFF;
        if8.op_b  = 8'h00;
        if8.start = 1'b1;
        q8.push_back('{diff: 8'hFF, bo: 1'b0, ovf: 1'b0});
      end
    end
    @(negedge clk);
    check("b2b_done_a", {if8.busy, if8.done}, 2'b01);
    @(posedge clk);
    #1 if8.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("b2b_busy_b", {if8.busy, if8.done}, 2'b10);
    end
    @(negedge clk);
    check("b2b_done_b", {if8.busy, if8.done}, 2'b01);

    // Reset in the middle of RUN aborts with no done pulse afterwards.
    @(negedge clk);
    if8.op_a      = 8'h05;
    if8.op_b      = 8'h03;
    if8.borrow_in = 1'b0;
    if8.start     = 1'b1;
    @(posedge clk);
    #1 if8.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("abort_busy", {if8.busy, if8.done}, 2'b10);
    end
    #2 rst_n = 1'b0;
    #1 check("abort_reset", {if8.busy, if8.done, if8.borrow_out, if8.ovf, if8.difference}, '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_idle", {if8.busy, if8.done}, 2'b00);
    issue8(8'h05, 8'h03, 1'b0, '{diff: 8'h02, bo: 1'b0, ovf: 1'b0});

    // Single-bit build.
    issue1(1'b0, 1'b1, 1'b0, '{diff: 1'b1, bo: 1'b1, ovf: 1'b1});
    issue1(1'b1, 1'b0, 1'b0, '{diff: 1'b1, bo: 1'b0, ovf: 1'b0});
    issue1(1'b1, 1'b1, 1'b1, '{diff: 1'b1, bo: 1'b1, ovf: 1'b0});
    issue1(1'b0, 1'b0, 1'b0, '{diff: 1'b0, bo: 1'b0, ovf: 1'b0});

    // Random operations against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      bin = 1'($urandom_range(0, 1));
      issue8(a, b, bin, model8(a, b, bin));
    end

    repeat (3) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_subtract_ctrl
